cozy_uart: RTL and testbench

Memory-mapped 8N1 UART peripheral on the cozy_cpu data bus. It is a sibling of cozy_memory: it watches the same mem_addr/mem_bwe/mem_dout lines and returns read data with the same one-cycle latency. The upstream read mux uses the registered hit flag to select this block's dout over RAM. The block provides a TX shift register and a small RX FIFO for the terminal host link.

---
 rtl/cozy_uart.sv | 199 +++++++++++++++++++
 tb/tb_cozy_uart.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cozy_uart.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// cozy_uart - memory-mapped 8N1 UART (TX shifter, RX FIFO) on the cozy_cpu bus.
// Rev 1.0
//==============================================================================
module cozy_uart #(
  parameter logic [15:0] BASE      = 16'hff00,
  parameter int          CLK_DIV   = 434,
  parameter int          FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addr,
  input  logic [1:0]  bwe,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        hit,
  input  logic        rxd,
  output logic        txd
);
  localparam int            CW       = $clog2(CLK_DIV);
  localparam int            DEPTH    = 1 << FIFO_LOG2;
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

  logic sel_data, sel_stat, data_rd, data_wr, stat_wr, data_rd_q, pop;
  logic [7:0] wr_byte;
  logic unused_addr0;

  assign sel_data     = addr[15:1] == BASE[15:1];
  assign sel_stat     = addr[15:1] == BASE[15:1] + 15'd1;
  assign data_rd      = sel_data && (bwe == 2'b00);
  assign data_wr      = sel_data && (bwe != 2'b00);
  assign stat_wr      = sel_stat && (bwe != 2'b00);
  assign wr_byte      = bwe[0] ? din[7:0] : din[15:8];
  assign unused_addr0 = addr[0];

  // RX FIFO and sticky flags
  logic [7:0]         mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr, rd_ptr;
  logic               empty, full, push_req, frame_bad, do_push;
  logic               overrun, fr_err, rx_avail, tx_busy;
  logic [7:0]         head, rx_sh;

  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                    (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign head     = mem[rd_ptr[FIFO_LOG2-1:0]];
  assign rx_avail = !empty;
  // Only the first cycle of a held DATA read pops.
  assign pop      = data_rd && !data_rd_q && !empty;
  assign do_push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_LOG2-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      overrun   <= 1'b0;
      fr_err    <= 1'b0;
      dout      <= 16'h0000;
      hit       <= 1'b0;
      data_rd_q <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (push_req && full && !pop)  overrun <= 1'b1;
      else if (stat_wr && wr_byte[2]) overrun <= 1'b0;
      if (frame_bad)                  fr_err <= 1'b1;
      else if (stat_wr && wr_byte[3]) fr_err <= 1'b0;
      hit       <= sel_data || sel_stat;
      data_rd_q <= data_rd;
      if (data_rd)
        dout <= empty ? 16'h0000 : {head, head};
      else if (sel_stat && bwe == 2'b00)
        dout <= {12'h000, fr_err, overrun, tx_busy, rx_avail};
      else
        dout <= 16'h0000;
    end
  end

  // TX shifter
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;

  assign tx_busy = tx_state != TX_IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'h00;
      txd      <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      if (data_wr) begin
        tx_state <= TX_START;
        tx_sh    <= wr_byte;
        tx_cnt   <= '0;
        txd      <= 1'b0;
      end
    end else if (tx_cnt != BIT_END) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_bit   <= 3'd0;
          txd      <= tx_sh[0];
        end
        TX_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            txd      <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            txd    <= tx_sh[1];
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX receiver
  rx_state_t     rx_state;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;

  assign push_req  = (rx_state == RX_STOP) && (rx_cnt == BIT_END) && rx_s2;
  assign frame_bad = (rx_state == RX_STOP) && (rx_cnt == BIT_END) && !rx_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h00;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT:  if (rx_s2) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cozy_uart.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_cozy_uart - vector table, hand sequences and random frames vs. a queue model.
// Rev 1.0
//==============================================================================
module tb_cozy_uart;
  localparam logic [15:0] BASE = 16'hff00;
  localparam logic [15:0] STAT = BASE + 16'd2;
  localparam int          DIV  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [1:0]  bwe = 2'b00;
  logic [15:0] din = 16'h0000;
  logic        rxd = 1'b1;
  logic [15:0] dout;
  logic        hit;
  logic        txd;

  cozy_uart #(.BASE(BASE), .CLK_DIV(DIV), .FIFO_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .bwe(bwe), .din(din),
    .dout(dout), .hit(hit), .rxd(rxd), .txd(txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a bounded queue plus the two sticky flags.
  logic [7:0] model_q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;

  typedef enum {OP_SEND, OP_BAD, OP_GLITCH, OP_RD, OP_WR} op_t;
  typedef struct {
    op_t         op;
    logic [15:0] a;
    logic [1:0]  w;
    logic [15:0] d;
    logic [15:0] exp;
    logic        exp_hit;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    addr = 16'h0000;
    bwe  = 2'b00;
    din  = 16'h0000;
  endtask

  function automatic logic [15:0] model_stat();
    return {12'h000, m_fe, m_ovr, 1'b0, model_q.size() != 0};
  endfunction

  function automatic logic [15:0] model_data();
    return (model_q.size() == 0) ? 16'h0000 : {model_q[0], model_q[0]};
  endfunction

  function automatic logic [39:0] tx_wave(input logic [7:0] b);
    logic [9:0]  frame;
    logic [39:0] w;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) w[i] = frame[i / DIV];
    return w;
  endfunction

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic h);
    addr = a;
    bwe  = 2'b00;
    tick();
    d = dout;
    h = hit;
    idle_bus();
    tick();
    if (a[15:1] == BASE[15:1] && model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [1:0] w, input logic [15:0] data);
    logic [7:0] lane;
    addr = a;
    bwe  = w;
    din  = data;
    tick();
    idle_bus();
    tick();
    lane = w[0] ? data[7:0] : data[15:8];
    if (a[15:1] == STAT[15:1]) begin
      if (lane[2]) m_ovr = 1'b0;
      if (lane[3]) m_fe  = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rxd = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) tick();
    end
    rxd = stop_ok;
    repeat (DIV) tick();
    rxd = 1'b1;
    repeat (6) tick();
    if (!stop_ok)                m_fe = 1'b1;
    else if (model_q.size() == 4) m_ovr = 1'b1;
    else                          model_q.push_back(b);
  endtask

  task automatic glitch();
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (8) tick();
  endtask

  // One TX frame while polling STATUS every cycle; optionally a write lands mid-frame.
  task automatic tx_frame(input logic [15:0] data, input logic [1:0] lanes, input logic drop);
    logic [7:0]  b;
    logic [39:0] got;
    logic [15:0] d;
    logic        h;
    int          busy;
    int          bad_idle;
    b    = lanes[0] ? data[7:0] : data[15:8];
    busy = 0;
    got  = '0;
    addr = BASE;
    bwe  = lanes;
    din  = data;
    tick();
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) got[i] = txd;
      else        check("tx_idle_after_stop", 64'(txd), 64'd1);
      if (drop && i == 10) begin
        addr = BASE;
        bwe  = 2'b01;
        din  = ~data;
      end else begin
        addr = STAT;
        bwe  = 2'b00;
      end
      tick();
      if (dout[1]) busy++;
    end
    idle_bus();
    check($sformatf("tx_wave_%02h", b), 64'(got), 64'(tx_wave(b)));
    if (!drop) check("tx_busy_cycles", 64'(busy), 64'd40);
    bad_idle = 0;
    for (int i = 0; i < 8; i++) begin
      if (txd !== 1'b1) bad_idle++;
      tick();
    end
    check("tx_line_idle", 64'(bad_idle), 64'd0);
    bus_read(STAT, d, h);
    check("tx_busy_clear", 64'(d[1]), 64'd0);
  endtask

  task automatic tx_b2b(input logic [7:0] b1, input logic [7:0] b2);
    logic [39:0] got;
    addr = BASE; bwe = 2'b01; din = {8'h00, b1};
    tick();
    idle_bus();
    repeat (39) tick();
    addr = BASE; bwe = 2'b01; din = {8'h00, ~b2};
    tick();
    idle_bus();
    check("b2b_stop_write_dropped", 64'(txd), 64'd1);
    addr = BASE; bwe = 2'b01; din = {8'h00, b2};
    tick();
    idle_bus();
    for (int i = 0; i < 40; i++) begin
      got[i] = txd;
      tick();
    end
    check("b2b_second_frame", 64'(got), 64'(tx_wave(b2)));
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic        rh;
    logic [15:0] exp;
    logic [7:0]  b;
    logic        ok;

    vecs.push_back('{OP_SEND,   16'h0000, 2'b00, 16'h005a, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0001, 1'b1});
    vecs.push_back('{OP_RD,     BASE,     2'b00, 16'h0000, 16'h5a5a, 1'b1});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{OP_RD,     16'h1234, 2'b00, 16'h0000, 16'h0000, 1'b0});
    for (int i = 1; i <= 5; i++)
      vecs.push_back('{OP_SEND, 16'h0000, 2'b00, 16'(i), 16'h0000, 1'b0});
    vecs.push_back('{OP_RD,     16'hff03, 2'b00, 16'h0000, 16'h0005, 1'b1});
    vecs.push_back('{OP_RD,     BASE,     2'b00, 16'h0000, 16'h0101, 1'b1});
    vecs.push_back('{OP_RD,     16'hff01, 2'b00, 16'h0000, 16'h0202, 1'b1});
    vecs.push_back('{OP_RD,     BASE,     2'b00, 16'h0000, 16'h0303, 1'b1});
    vecs.push_back('{OP_RD,     BASE,     2'b00, 16'h0000, 16'h0404, 1'b1});
    vecs.push_back('{OP_RD,     BASE,     2'b00, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0004, 1'b1});
    vecs.push_back('{OP_WR,     STAT,     2'b01, 16'h0004, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{OP_BAD,    16'h0000, 2'b00, 16'h0033, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0008, 1'b1});
    vecs.push_back('{OP_RD,     BASE,     2'b00, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{OP_GLITCH, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0008, 1'b1});
    vecs.push_back('{OP_WR,     STAT,     2'b10, 16'h0800, 16'h0000, 1'b0});
    vecs.push_back('{OP_RD,     STAT,     2'b00, 16'h0000, 16'h0000, 1'b1});

    // Reset state, with a selected address on the bus.
    addr = STAT;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_hit",  64'(hit),  64'd0);
    check("reset_txd",  64'(txd),  64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    idle_bus();
    repeat (3) tick();

    // TX: the 0x41 frame, a dropped mid-frame write, then back-to-back.
    tx_frame(16'h0041, 2'b01, 1'b0);
    tx_frame(16'h4100, 2'b10, 1'b1);
    tx_frame(16'h3c41, 2'b11, 1'b0);
    tx_b2b(8'ha5, 8'h3c);

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_SEND:   send_frame(vecs[i].d[7:0], 1'b1);
        OP_BAD:    send_frame(vecs[i].d[7:0], 1'b0);
        OP_GLITCH: glitch();
        OP_WR:     bus_write(vecs[i].a, vecs[i].w, vecs[i].d);
        default: begin
          bus_read(vecs[i].a, rd, rh);
          check($sformatf("vec%0d_dout", i), 64'(rd), 64'(vecs[i].exp));
          check($sformatf("vec%0d_hit", i),  64'(rh), 64'(vecs[i].exp_hit));
        end
      endcase
    end

    // Held DATA read pops only once.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    addr = BASE;
    bwe  = 2'b00;
    tick();
    check("hold_first", 64'(dout), 64'h1111);
    tick();
    tick();
    check("hold_third", 64'(dout), 64'h2222);
    idle_bus();
    tick();
    void'(model_q.pop_front());
    bus_read(BASE, rd, rh);
    check("hold_next_read", 64'(rd), 64'h2222);
    bus_read(STAT, rd, rh);
    check("hold_stat", 64'(rd), 64'h0000);

    // Randomized RX traffic against the queue model.
    for (int n = 0; n < 10; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      if ($urandom_range(0, 1) == 1) begin
        exp = model_data();
        bus_read(BASE, rd, rh);
        check($sformatf("rand%0d_data", n), 64'(rd), 64'(exp));
      end
      exp = model_stat();
      bus_read(STAT, rd, rh);
      check($sformatf("rand%0d_stat", n), 64'(rd), 64'(exp));
    end
    for (int n = 0; n < 5; n++) begin
      exp = model_data();
      bus_read(BASE, rd, rh);
      check($sformatf("drain%0d", n), 64'(rd), 64'(exp));
    end
    bus_write(STAT, 2'b01, 16'h000c);
    bus_read(STAT, rd, rh);
    check("drain_stat", 64'(rd), 64'h0000);

    // Randomized TX frames.
    for (int n = 0; n < 3; n++)
      tx_frame(16'($urandom), 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));

    // Reset in the middle of a start bit.
    addr = BASE; bwe = 2'b01; din = 16'h0000;
    tick();
    addr = STAT; bwe = 2'b00;
    tick();
    check("midtx_busy", 64'(dout), 64'h0002);
    check("midtx_txd_low", 64'(txd), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midtx_reset_txd",  64'(txd),  64'd1);
    check("midtx_reset_dout", 64'(dout), 64'd0);
    check("midtx_reset_hit",  64'(hit),  64'd0);
    model_q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_bus();
    repeat (2) tick();
    bus_read(STAT, rd, rh);
    check("post_reset_stat", 64'(rd), 64'h0000);
    check("post_reset_txd", 64'(txd), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
